// File: rtl/sample_framer_pkg.sv
// ---------------------------------------------------------------------------
// sample_framer_pkg
//   Shared definitions for the sample framer slice: default parameter values,
//   the framing FSM state encoding and a small width helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package sample_framer_pkg;

    localparam int DW_DEFAULT         = 14;
    localparam int FRAME_LEN_DEFAULT  = 17;
    localparam int GAP_LEN_DEFAULT    = 4;
    localparam int FIFO_DEPTH_DEFAULT = 32;
    localparam int PTR_W_DEFAULT      = $clog2(FIFO_DEPTH_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } frame_state_t;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
//   Single-clock FIFO holding one sample triplet per entry. DEPTH must be a
//   power of two so the pointers wrap by natural overflow.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, empties the FIFO
//   push     in   write wr_data this cycle (ignored when full)
//   pop      in   advance the read pointer this cycle (ignored when empty)
//   wr_data  in   WIDTH-bit entry to write
//   rd_data  out  WIDTH-bit entry at the head (combinational read)
//   count    out  number of stored entries, 0..DEPTH
//   full     out  count == DEPTH
// ---------------------------------------------------------------------------
module sample_fifo
    import sample_framer_pkg::*;
#(
    parameter int WIDTH = 3 * DW_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int PTR_W = ctr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [PTR_W:0]   count,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A simultaneous push and pop moves both pointers and keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_framer.sv
// ---------------------------------------------------------------------------
// sample_framer
//   Buffers incoming {ch2, ch3, ref} triplets and emits them in frames of
//   FRAME_LEN consecutive samples (head_flag high), separated by at least
//   GAP_LEN idle cycles. A frame only starts once FRAME_LEN triplets are
//   stored, so a frame is never short.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset; aborts any frame and
//                   discards all buffered samples
//   s_valid    in   input triplet valid
//   s_ready    out  a triplet can be accepted this cycle (FIFO not full)
//   s_ch2      in   channel-2 sample
//   s_ch3      in   channel-3 sample
//   s_ref      in   reference sample
//   buffer_2   out  channel-2 frame sample (registered, 0 outside frames)
//   buffer_3   out  channel-3 frame sample (registered, 0 outside frames)
//   reff       out  reference frame sample (registered, 0 outside frames)
//   head_flag  out  high for the FRAME_LEN cycles of each frame (registered)
//   frame_cnt  out  completed-frame counter, 16 bits, wraps; present only
//                   when SAMPLE_FRAMER_FCNT_EN is defined
//
// Build option: `define SAMPLE_FRAMER_FCNT_EN to add the frame_cnt output.
// ---------------------------------------------------------------------------
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
    parameter int GAP_LEN    = GAP_LEN_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_ch2,
    input  logic [DW-1:0] s_ch3,
    input  logic [DW-1:0] s_ref,
    output logic [DW-1:0] buffer_2,
    output logic [DW-1:0] buffer_3,
    output logic [DW-1:0] reff,
    output logic          head_flag
`ifdef SAMPLE_FRAMER_FCNT_EN
   ,output logic [15:0]   frame_cnt
`endif
);

    localparam int FCW = ctr_width(FRAME_LEN);
    localparam int GCW = ctr_width(GAP_LEN);
    localparam int CW  = ctr_width(FIFO_DEPTH) + 1;

    frame_state_t    state;
    frame_state_t    state_next;
    logic [FCW-1:0]  frame_ctr;
    logic [GCW-1:0]  gap_ctr;
    logic [CW-1:0]   fill;
    logic            fifo_full;
    logic            pop;
    logic [3*DW-1:0] fifo_wr;
    logic [3*DW-1:0] fifo_rd;

    assign fifo_wr = {s_ch2, s_ch3, s_ref};
    assign s_ready = ~fifo_full;

    // An entry is popped in every cycle whose next state is FRAME: the IDLE
    // cycle that decides to start plus the first FRAME_LEN-1 FRAME cycles.
    // The popped sample lands in the output registers at that edge, so
    // head_flag is high exactly while the FSM sits in FRAME.
    assign pop = (state_next == ST_FRAME);

    sample_fifo #(
        .WIDTH (3 * DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid),
        .pop     (pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .count   (fill),
        .full    (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (fill >= CW'(FRAME_LEN)) begin
                    state_next = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (frame_ctr == FCW'(FRAME_LEN - 1)) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_ctr == GCW'(GAP_LEN - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Both counters restart from zero whenever the state changes, so each
    // FRAME and GAP visit counts its own cycles from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ctr <= '0;
            gap_ctr   <= '0;
        end else if (state_next != state) begin
            frame_ctr <= '0;
            gap_ctr   <= '0;
        end else begin
            if (state == ST_FRAME) begin
                frame_ctr <= frame_ctr + FCW'(1);
            end
            if (state == ST_GAP) begin
                gap_ctr <= gap_ctr + GCW'(1);
            end
        end
    end

    // Outputs carry the popped triplet during a frame and are held at zero
    // otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_flag <= 1'b0;
            buffer_2  <= '0;
            buffer_3  <= '0;
            reff      <= '0;
        end else if (pop) begin
            head_flag <= 1'b1;
            buffer_2  <= fifo_rd[3*DW-1:2*DW];
            buffer_3  <= fifo_rd[2*DW-1:DW];
            reff      <= fifo_rd[DW-1:0];
        end else begin
            head_flag <= 1'b0;
            buffer_2  <= '0;
            buffer_3  <= '0;
            reff      <= '0;
        end
    end

`ifdef SAMPLE_FRAMER_FCNT_EN
    // Counts completed frames at the FRAME to GAP hand-over; wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if ((state == ST_FRAME) && (state_next == ST_GAP)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
